// File: rtl/c16_arb_pkg.sv
// Shared types and the C16 core-bus to external-memory address map for c16_mem_arbiter.
// Memory address bit 16 selects the bank: 0 = RAM, 1 = ROM (bit 15 then picks low/high ROM).
package c16_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CORE_ACC,
      HOST_ACC
   } arb_state_t;

   localparam int MAP_AW  = 17;
   localparam int ROM_BIT = 16;

   localparam logic [MAP_AW-1:0] RAM_BASE    = '0;
   localparam logic [MAP_AW-1:0] ROM_LO_BASE = MAP_AW'(1) << ROM_BIT;
   localparam logic [MAP_AW-1:0] ROM_HI_BASE = ROM_LO_BASE | (MAP_AW'(1) << (ROM_BIT - 1));

   // RAM select wins over cs0, which wins over cs1; ROM banks are 32K so addr[15] is dropped.
   function automatic logic [MAP_AW-1:0] core_map(input logic [15:0] addr,
                                                  input logic        cs_ram,
                                                  input logic        cs0);
      logic [MAP_AW-1:0] a;
      if (cs_ram)
         a = RAM_BASE | {1'b0, addr};
      else if (cs0)
         a = ROM_LO_BASE | {2'b00, addr[14:0]};
      else
         a = ROM_HI_BASE | {2'b00, addr[14:0]};
      return a;
   endfunction

endpackage

// File: rtl/c16_mem_arbiter_if.sv
// External memory port of the arbiter: single-cycle mem_req, fields held until a one-cycle mem_ack.
// master = arbiter side, slave = SDRAM controller side.
interface c16_mem_arbiter_if #(
   parameter int MEM_AW = 17
) ();
   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/c16_arb_starve.sv
// Host starvation tracker: counts core cycles served while the host waits and raises core_wait
// once HOST_TIMEOUT is reached, until the host is acknowledged or withdraws its request.
module c16_arb_starve #(
   parameter int HOST_TIMEOUT = 64,
   parameter int TO_W         = 7
) (
   input  logic CLK28,
   input  logic RESET,
   input  logic core_served,
   input  logic host_waiting,
   input  logic host_req,
   input  logic host_ack,
   output logic core_wait
);
   logic [TO_W-1:0] starve_cnt;

   always_ff @(posedge CLK28) begin
      if (RESET || !host_req || host_ack) begin
         starve_cnt <= '0;
         core_wait  <= 1'b0;
      end else if (core_served && host_waiting && starve_cnt != TO_W'(HOST_TIMEOUT)) begin
         // core_wait rises together with the count reaching the timeout and then holds
         starve_cnt <= starve_cnt + TO_W'(1);
         core_wait  <= (starve_cnt == TO_W'(HOST_TIMEOUT - 1));
      end
   end
endmodule

// File: rtl/c16_mem_arbiter.sv
// Shares one external memory port between the C16 core bus (always first) and a host loader.
// Build macro C16_ARB_ROMWP_EN: core writes to the ROM banks are dropped without a memory cycle.
module c16_mem_arbiter
   import c16_arb_pkg::*;
#(
   parameter int MEM_AW       = 17,
   parameter int HOST_TIMEOUT = 64,
   parameter int TO_W         = 7
) (
   input  logic              CLK28,
   input  logic              RESET,
   input  logic              core_strobe,
   input  logic [15:0]       core_addr,
   input  logic              core_rnw,
   input  logic [7:0]        core_wdata,
   input  logic              core_cs_ram,
   input  logic              core_cs0,
   input  logic              core_cs1,
   output logic [7:0]        core_rdata,
   output logic              core_wait,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [MEM_AW-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic [7:0]        host_rdata,
   output logic              host_ack,
   c16_mem_arbiter_if.master mem
);
   arb_state_t        state_reg, state_next;
   logic              start_core, start_host, use_new;
   logic              core_drop, core_take;
   logic [MEM_AW-1:0] new_addr, sel_addr;
   logic              sel_we;
   logic [7:0]        sel_wdata;
   logic              pend_reg, pend_we_reg, cur_rnw_reg;
   logic [MEM_AW-1:0] pend_addr_reg;
   logic [7:0]        pend_wdata_reg;
   logic              mem_req_reg, mem_we_reg;
   logic [MEM_AW-1:0] mem_addr_reg;
   logic [7:0]        mem_wdata_reg;
   logic              host_waiting;

`ifdef C16_ARB_ROMWP_EN
   assign core_drop = !core_cs_ram && !core_rnw;
`else
   assign core_drop = 1'b0;
`endif

   assign core_take = core_strobe && (core_cs_ram || core_cs0 || core_cs1) && !core_drop;
   assign new_addr  = MEM_AW'(core_map(core_addr, core_cs_ram, core_cs0));
   assign sel_addr  = use_new ? new_addr     : pend_addr_reg;
   assign sel_we    = use_new ? !core_rnw    : pend_we_reg;
   assign sel_wdata = use_new ? core_wdata   : pend_wdata_reg;

   always_comb begin
      state_next = state_reg;
      start_core = 1'b0;
      start_host = 1'b0;
      use_new    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (core_take) begin
               start_core = 1'b1;
               use_new    = 1'b1;
               state_next = CORE_ACC;
            end else if (host_req && !host_ack) begin
               start_host = 1'b1;
               state_next = HOST_ACC;
            end
         end
         CORE_ACC, HOST_ACC: begin
            // a strobe landing on the ack clock is newer than any latched one
            if (mem.mem_ack) begin
               if (core_take) begin
                  start_core = 1'b1;
                  use_new    = 1'b1;
                  state_next = CORE_ACC;
               end else if (pend_reg) begin
                  start_core = 1'b1;
                  state_next = CORE_ACC;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK28) begin
      if (RESET) begin
         state_reg      <= IDLE;
         mem_req_reg    <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         core_rdata     <= 8'hFF;
         host_rdata     <= '0;
         host_ack       <= 1'b0;
         pend_reg       <= 1'b0;
         pend_we_reg    <= 1'b0;
         pend_addr_reg  <= '0;
         pend_wdata_reg <= '0;
         cur_rnw_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         mem_req_reg <= start_core || start_host;
         host_ack    <= 1'b0;
         if (start_core) begin
            mem_addr_reg  <= sel_addr;
            mem_we_reg    <= sel_we;
            mem_wdata_reg <= sel_wdata;
            cur_rnw_reg   <= !sel_we;
         end else if (start_host) begin
            mem_addr_reg  <= host_addr;
            mem_we_reg    <= host_we;
            mem_wdata_reg <= host_wdata;
            cur_rnw_reg   <= 1'b0;
         end
         if (state_reg == CORE_ACC && mem.mem_ack && cur_rnw_reg)
            core_rdata <= mem.mem_rdata;
         if (state_reg == HOST_ACC && mem.mem_ack) begin
            host_ack   <= 1'b1;
            host_rdata <= mem.mem_rdata;
         end
         if (state_reg != IDLE && mem.mem_ack) begin
            pend_reg <= 1'b0;
         end else if (state_reg != IDLE && core_take) begin
            pend_reg       <= 1'b1;
            pend_addr_reg  <= new_addr;
            pend_we_reg    <= !core_rnw;
            pend_wdata_reg <= core_wdata;
         end
      end
   end

   assign mem.mem_req   = mem_req_reg;
   assign mem.mem_we    = mem_we_reg;
   assign mem.mem_addr  = mem_addr_reg;
   assign mem.mem_wdata = mem_wdata_reg;

   // the host is only starving while it is neither in service nor just acknowledged
   assign host_waiting = host_req && !host_ack && (state_reg != HOST_ACC);

   c16_arb_starve #(
      .HOST_TIMEOUT(HOST_TIMEOUT),
      .TO_W        (TO_W)
   ) u_starve (
      .CLK28       (CLK28),
      .RESET       (RESET),
      .core_served (start_core),
      .host_waiting(host_waiting),
      .host_req    (host_req),
      .host_ack    (host_ack),
      .core_wait   (core_wait)
   );
endmodule
